zrle_comp: RTL and testbench

- ZRLE compressor: the encode-side counterpart of the decoder in the same datapath.
- Captures a 16-word burst of 64-bit data, where each word is four 16-bit lanes.
- Encodes each word with the zero-lane run-length code table and packs the codes MSB-first into exactly 8 output words.
- If the burst does not fit in 8 words, it passes the 16 words through raw and flags them on a sideband.

---
 rtl/zrle_comp.sv | 200 ++++++++++++++++++++
 tb/tb_zrle_comp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zrle_comp.sv
// ZRLE compressor: captures a 16-word burst of four 16-bit lanes, encodes each word with
// the zero-lane run-length code and emits 8 packed words, or the 16 raw words if they do not fit.
module zrle_comp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [63:0] data_i,
  input  logic        sop_i,
  input  logic        eop_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [63:0] data_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic        comp_o,
  input  logic        ready_i
);

  localparam int BURST_LEN = 16;
  localparam int OUT_WORDS = 8;
  localparam int MAX_BITS  = 510;
  localparam logic [511:0] HEADER = {2'b01, 510'd0};

  typedef enum logic [1:0] {CAPTURE, EMIT_C, EMIT_R} state_e;

  typedef struct packed {
    logic [65:0] bits;   // code left-aligned, MSB first
    logic [6:0]  len;
  } code_t;

  function automatic code_t encode(input logic [63:0] w);
    logic [15:0] l3, l2, l1, l0;
    code_t       c;
    l3 = w[63:48];
    l2 = w[47:32];
    l1 = w[31:16];
    l0 = w[15:0];
    c.bits = '0;
    c.len  = 7'd6;
    case ({|l3, |l2, |l1, |l0})
      4'b0000: begin c.bits = {6'b000000, 60'd0};         c.len = 7'd6;  end
      4'b0001: begin c.bits = {6'b000001, l0, 44'd0};     c.len = 7'd22; end
      4'b0010: begin c.bits = {5'b00001, l1, 45'd0};      c.len = 7'd21; end
      4'b0100: begin c.bits = {5'b00010, l2, 45'd0};      c.len = 7'd21; end
      4'b1000: begin c.bits = {5'b00011, l3, 45'd0};      c.len = 7'd21; end
      4'b0011: begin c.bits = {4'b0010, l1, l0, 30'd0};   c.len = 7'd36; end
      4'b0101: begin c.bits = {4'b0011, l2, l0, 30'd0};   c.len = 7'd36; end
      4'b1001: begin c.bits = {4'b0100, l3, l0, 30'd0};   c.len = 7'd36; end
      4'b0110: begin c.bits = {4'b0101, l2, l1, 30'd0};   c.len = 7'd36; end
      4'b1010: begin c.bits = {4'b0110, l3, l1, 30'd0};   c.len = 7'd36; end
      4'b1100: begin c.bits = {4'b0111, l3, l2, 30'd0};   c.len = 7'd36; end
      4'b0111: begin c.bits = {4'b1000, l2, l1, l0, 14'd0}; c.len = 7'd52; end
      4'b1011: begin c.bits = {4'b1001, l3, l1, l0, 14'd0}; c.len = 7'd52; end
      4'b1101: begin c.bits = {4'b1010, l3, l2, l0, 14'd0}; c.len = 7'd52; end
      4'b1110: begin c.bits = {4'b1011, l3, l2, l1, 14'd0}; c.len = 7'd52; end
      default: begin c.bits = {2'b11, w};                 c.len = 7'd66; end
    endcase
    return c;
  endfunction

  state_e state_q, state_d;

  logic [3:0]                  count_q, count_d;
  logic [10:0]                 total_q, total_d;
  logic                        active_q, active_d;
  logic [OUT_WORDS-1:0][63:0]  stream_q, stream_d;
  logic [4:0]                  out_idx_q, out_idx_d;
  logic                        valid_q, valid_d;
  logic [63:0]                 data_q, data_d;
  logic                        sop_q, sop_d, eop_q, eop_d, comp_q, comp_d;

  logic [63:0] buf_mem [BURST_LEN];

  logic                       accept, take, restart, last_word;
  logic [3:0]                 wr_idx;
  logic [10:0]                base_total, new_total;
  logic [OUT_WORDS-1:0][63:0] base_stream;
  logic [511:0]               code_shift;
  code_t                      code;
  logic                       emit_comp, load, out_xfer, done;
  logic [4:0]                 n_words;
  logic                       unused_eop;

  assign unused_eop = eop_i;   // capture ends on the 16th word, never on eop_i

  // A word at count 0 opens a fresh stream even without sop_i, so the header is never lost.
  assign accept     = valid_i & (state_q == CAPTURE);
  assign take       = accept & (sop_i | active_q);
  assign restart    = sop_i | (count_q == 4'd0);
  assign wr_idx     = restart ? 4'd0 : count_q;
  assign base_total = restart ? 11'd0 : total_q;
  assign base_stream = restart ? HEADER : stream_q;
  assign code       = encode(data_i);
  assign new_total  = base_total + {4'd0, code.len};
  assign code_shift = {code.bits, 446'd0} >> (base_total + 11'd2);
  assign last_word  = take & (wr_idx == 4'(BURST_LEN - 1));

  assign out_xfer = valid_q & ready_i;
  assign done     = out_xfer & eop_q;
  assign load     = (state_q != CAPTURE) & (~valid_q | ready_i) & (out_idx_q < n_words);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CAPTURE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (last_word) state_d = (new_total <= 11'(MAX_BITS)) ? EMIT_C : EMIT_R;
      EMIT_C, EMIT_R: if (done) state_d = CAPTURE;
      default: state_d = CAPTURE;
    endcase
  end

  always_comb begin
    ready_o   = (state_q == CAPTURE);
    emit_comp = (state_q == EMIT_C);
    n_words   = emit_comp ? 5'd8 : 5'd16;
  end

  // NOTE: the burst buffer carries no reset; nothing reads an entry before capture writes it.
  always_ff @(posedge clk) begin
    if (take) buf_mem[wr_idx] <= data_i;
  end

  // The compressed stream is assembled during capture, so emission never waits on packing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    count_d   = count_q;
    total_d   = total_q;
    active_d  = active_q;
    stream_d  = stream_q;
    out_idx_d = out_idx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    comp_d    = comp_q;

    if (take) begin
      count_d  = last_word ? 4'd0 : wr_idx + 4'd1;
      total_d  = new_total;
      stream_d = base_stream | code_shift;
      active_d = 1'b1;
    end

    if (out_xfer) valid_d = 1'b0;

    if (load) begin
      valid_d   = 1'b1;
      data_d    = emit_comp ? stream_q[3'd7 - out_idx_q[2:0]] : buf_mem[out_idx_q[3:0]];
      sop_d     = (out_idx_q == 5'd0);
      eop_d     = (out_idx_q == n_words - 5'd1);
      comp_d    = emit_comp;
      out_idx_d = out_idx_q + 5'd1;
    end

    if (done) begin
      count_d   = 4'd0;
      total_d   = 11'd0;
      stream_d  = '0;
      out_idx_d = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 4'd0;
      total_q   <= 11'd0;
      active_q  <= 1'b0;
      stream_q  <= '0;
      out_idx_q <= 5'd0;
      valid_q   <= 1'b0;
      data_q    <= 64'd0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      comp_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      total_q   <= total_d;
      active_q  <= active_d;
      stream_q  <= stream_d;
      out_idx_q <= out_idx_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      comp_q    <= comp_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign comp_o  = comp_q;

endmodule

// File: tb/tb_zrle_comp.sv
// Self-checking bench for zrle_comp: a bit-queue reference model of the ZRLE code table
// drives the expected output stream, checked on every output handshake and every stall cycle.
module tb_zrle_comp;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, sop_i, eop_i, ready_i;
  logic [63:0] data_i;
  logic        ready_o, valid_o, sop_o, eop_o, comp_o;
  logic [63:0] data_o;

  zrle_comp dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .data_i (data_i),
    .sop_i  (sop_i),
    .eop_i  (eop_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .sop_o  (sop_o),
    .eop_o  (eop_o),
    .comp_o (comp_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sop, eop, comp;
  } out_t;

  out_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mdl_bits[$];
  logic [63:0] mdl_buf[16];
  int          mdl_cnt = 0;
  bit          mdl_active = 0;
  int          mdl_total = 0;
  int          rdy_mode = 0;   // 0: ready held high, 1: toggle every cycle, 2: driven by the test
  bit          thru_chk = 0;

  localparam logic [63:0] A = 64'h1111_2222_3333_4444;  // 66-bit code
  localparam logic [63:0] B = 64'h0000_0000_5555_0000;  // 21-bit code
  localparam logic [63:0] C = 64'h0000_0000_0000_00A5;  // 22-bit code
  localparam logic [63:0] Z = 64'h0;                    // 6-bit code

  logic [63:0] zeros[16], abcd[16], rawb[16], mix510[16], mix511[16];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_field(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mdl_bits.push_back(v[i]);
  endfunction

  function automatic void model_word(input logic [63:0] w);
    int nz[$];
    int zl;
    for (int k = 3; k >= 0; k--) if (w[16*k +: 16] != 16'd0) nz.push_back(k);
    case (nz.size())
      0: push_field(64'd0, 6);
      1: if (nz[0] == 0) push_field(64'd1, 6); else push_field(64'(nz[0]), 5);
      2: case (nz[0] * 4 + nz[1])
           4:  push_field(64'd2, 4);
           8:  push_field(64'd3, 4);
           12: push_field(64'd4, 4);
           9:  push_field(64'd5, 4);
           13: push_field(64'd6, 4);
           default: push_field(64'd7, 4);
         endcase
      3: begin
           zl = 6 - (nz[0] + nz[1] + nz[2]);
           push_field(64'(8 + (3 - zl)), 4);
         end
      default: push_field(64'd3, 2);
    endcase
    foreach (nz[i]) push_field(64'(w[16*nz[i] +: 16]), 16);
  endfunction

  function automatic void model_build();
    out_t e;
    mdl_bits.delete();
    push_field(64'd1, 2);
    for (int i = 0; i < 16; i++) model_word(mdl_buf[i]);
    mdl_total = mdl_bits.size() - 2;
    if (mdl_total <= 510) begin
      while (mdl_bits.size() < 512) mdl_bits.push_back(1'b0);
      for (int w = 0; w < 8; w++) begin
        for (int b = 0; b < 64; b++) e.data[63-b] = mdl_bits[64*w + b];
        e.sop = (w == 0); e.eop = (w == 7); e.comp = 1'b1;
        exp_q.push_back(e);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        e.data = mdl_buf[i]; e.sop = (i == 0); e.eop = (i == 15); e.comp = 1'b0;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void model_accept(input logic [63:0] w, input bit sop);
    if (sop) begin mdl_active = 1; mdl_cnt = 0; end
    if (!mdl_active) return;
    mdl_buf[mdl_cnt] = w;
    mdl_cnt++;
    if (mdl_cnt == 16) begin model_build(); mdl_cnt = 0; end
  endfunction

  // ---------------- drivers ----------------
  task automatic send_word(input logic [63:0] w, input bit sop, input bit eop);
    int t = 0;
    while (!ready_o && t < 200) begin @(posedge clk); #1; t++; end
    if (!ready_o) begin check(1'b0, "ready_wait", 64'(ready_o), 64'd1); return; end
    valid_i = 1'b1; data_i = w; sop_i = sop; eop_i = eop;
    @(posedge clk);
    model_accept(w, sop);
    #1;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic send_burst(input logic [63:0] w[16]);
    for (int i = 0; i < 16; i++) send_word(w[i], i == 0, i == 15);
  endtask

  task automatic ready_and_latency();
    int lat = 0;
    check(ready_o == 1'b0, "ready_drop", 64'(ready_o), 64'd0);
    while (!valid_o && lat < 10) begin @(posedge clk); #1; lat++; end
    check(valid_o && lat <= 3, "latency", 64'(lat), 64'd3);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin @(posedge clk); #1; t++; end
    check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    check(ready_o == 1'b1, "ready_back", 64'(ready_o), 64'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) ready_i = 1'b1;
      else if (rdy_mode == 1) ready_i = ~ready_i;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    bit         prev_stall = 0;
    bit         in_burst = 0;
    logic [66:0] prev;
    out_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; in_burst = 0;
      end else begin
        if (prev_stall)
          check(valid_o && {data_o, sop_o, eop_o} == prev[66:1] && comp_o == prev[0],
                "stall_hold", data_o, prev[66:3]);
        if (thru_chk && in_burst) check(valid_o, "no_bubble", 64'(valid_o), 64'd1);
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_output", data_o, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check(data_o === e.data, "data", data_o, e.data);
            check({sop_o, eop_o, comp_o} === {e.sop, e.eop, e.comp}, "sideband",
                  64'({sop_o, eop_o, comp_o}), 64'({e.sop, e.eop, e.comp}));
          end
          if (sop_o) in_burst = 1;
          if (eop_o) in_burst = 0;
        end
        prev_stall = valid_o && !ready_i;
        prev = {data_o, sop_o, eop_o, comp_o};
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    zeros  = '{default: Z};
    abcd   = '{default: Z};
    abcd[0] = 64'h0000_0000_0000_ABCD;
    rawb   = '{default: A};
    mix510 = '{A, C, C, B, C, A, C, C, Z, C, A, C, B, C, A, C};
    mix511 = '{A, C, C, B, C, A, C, C, Z, C, A, C, C, C, A, C};

    rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(valid_o == 1'b0, "rst_valid", 64'(valid_o), 64'd0);
    check(ready_o == 1'b1, "rst_ready", 64'(ready_o), 64'd1);
    check(data_o == 64'd0, "rst_data", data_o, 64'd0);
    check({sop_o, eop_o, comp_o} == 3'b000, "rst_side", 64'({sop_o, eop_o, comp_o}), 64'd0);
    rst_n = 1'b1;

    // words before the first sop are dropped
    send_word(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    send_word(64'hDEAD_BEEF_0000_0002, 1'b0, 1'b0);

    // all-zero burst
    thru_chk = 1;
    send_burst(zeros);
    check(mdl_total == 96, "mdl_total_zero", 64'(mdl_total), 64'd96);
    check(exp_q.size() == 8 && exp_q[0].data == 64'h4000_0000_0000_0000, "mdl_word0_zero",
          exp_q[0].data, 64'h4000_0000_0000_0000);
    ready_and_latency();
    drain();

    // single nonzero lane0 word
    send_burst(abcd);
    check(exp_q[0].data == 64'h41AB_CD00_0000_0000, "mdl_word0_abcd", exp_q[0].data,
          64'h41AB_CD00_0000_0000);
    ready_and_latency();
    drain();

    // incompressible burst, stall on the last word
    thru_chk = 0;
    rdy_mode = 2;
    ready_i = 1'b1;
    send_burst(rawb);
    check(mdl_total == 1056 && exp_q.size() == 16 && exp_q[0].comp == 1'b0, "mdl_raw",
          64'(mdl_total), 64'd1056);
    begin
      int t = 0;
      while (!(valid_o && eop_o) && t < 100) begin @(posedge clk); #1; t++; end
      check(valid_o && eop_o, "eop_seen", 64'(eop_o), 64'd1);
      ready_i = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        check(valid_o && eop_o, "eop_hold", 64'({valid_o, eop_o}), 64'd3);
      end
      ready_i = 1'b1;
    end
    drain();

    // total exactly 510 with ready toggling, and valid_i ignored during emission
    rdy_mode = 1;
    send_burst(mix510);
    check(mdl_total == 510 && exp_q.size() == 8, "mdl_510", 64'(mdl_total), 64'd510);
    check(ready_o == 1'b0, "ready_drop_510", 64'(ready_o), 64'd0);
    valid_i = 1'b1; sop_i = 1'b1; data_i = 64'hFFFF_0000_FFFF_0000;
    repeat (3) @(posedge clk);
    #1;
    valid_i = 1'b0; sop_i = 1'b0;
    drain();

    // total 511 goes raw
    rdy_mode = 0;
    @(posedge clk); #1;
    thru_chk = 1;
    send_burst(mix511);
    check(mdl_total == 511 && exp_q.size() == 16, "mdl_511", 64'(mdl_total), 64'd511);
    ready_and_latency();
    drain();

    // sop reasserted after 5 words restarts the burst
    send_word(A, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) send_word(A, 1'b0, 1'b0);
    send_burst(mix510);
    check(exp_q.size() == 8, "restart_len", 64'(exp_q.size()), 64'd8);
    drain();

    // reset in the middle of emission
    send_burst(rawb);
    begin
      int t = 0;
      while (exp_q.size() > 13 && t < 100) begin @(posedge clk); #1; t++; end
      check(exp_q.size() <= 13, "emit_progress", 64'(exp_q.size()), 64'd13);
    end
    rst_n = 1'b0;
    exp_q.delete();
    mdl_active = 0; mdl_cnt = 0;
    #1;
    check(valid_o == 1'b0, "midrst_valid", 64'(valid_o), 64'd0);
    check(ready_o == 1'b1, "midrst_ready", 64'(ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_burst(abcd);
    ready_and_latency();
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
